// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_master_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_ADDR_W = 11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  typedef struct packed {
    logic                    rnw;
    logic [AXI_ADDR_W-1:0]   addr;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
  } cmd_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            resp;
    logic                  timeout;
  } rsp_t;

endpackage

// File: rtl/axil_timeout_counter.sv
// Saturating cycle counter bounding the wait for BVALID/RVALID.
module axil_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Count is 0 in the first waiting cycle, so this fires on the last allowed one.
  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: one register read or write per accepted command.
module axil_cmd_master
  import axil_master_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int C_M_AXI_ADDR_WIDTH = AXI_ADDR_W,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            stale_rsp,
  output logic [2:0]                      dbg_state,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  // Handshake rule on every channel here: a transfer happens on a rising clk
  // edge where valid and ready are both high; valid never drops before that.

  state_t state_q, state_d;
  cmd_t   cmd_in;
  rsp_t   rsp_q, rsp_d;
  logic   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic   cmd_take, stale_q;
  logic   to_clear, to_enable, to_expired;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;

  assign cmd_in = '{rnw: cmd_rnw, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};

  axil_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_comb begin
    state_d       = state_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_d         = rsp_q;
    cmd_take      = 1'b0;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    to_clear      = 1'b0;
    to_enable     = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          // Readies stay high while idle so stray B/R beats are drained.
          cmd_ready    = 1'b1;
          M_AXI_BREADY = 1'b1;
          M_AXI_RREADY = 1'b1;
          if (cmd_valid) begin
            cmd_take  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = cmd_in.rnw ? ST_RD_REQ : ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          M_AXI_AWVALID = !aw_done_q;
          M_AXI_WVALID  = !w_done_q;
          if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
          if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
          if (aw_done_d && w_done_d) begin
            to_clear = 1'b1;
            state_d  = ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          M_AXI_BREADY = 1'b1;
          to_enable    = 1'b1;
          if (M_AXI_BVALID) begin
            rsp_d   = '{rdata: '0, resp: M_AXI_BRESP, timeout: 1'b0};
            state_d = ST_RSP;
          end else if (to_expired) begin
            rsp_d   = '{rdata: '0, resp: RESP_DECERR, timeout: 1'b1};
            state_d = ST_RSP;
          end
        end
        ST_RD_REQ: begin
          M_AXI_ARVALID = 1'b1;
          if (M_AXI_ARREADY) begin
            to_clear = 1'b1;
            state_d  = ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          M_AXI_RREADY = 1'b1;
          to_enable    = 1'b1;
          if (M_AXI_RVALID) begin
            rsp_d   = '{rdata: M_AXI_RDATA, resp: M_AXI_RRESP, timeout: 1'b0};
            state_d = ST_RSP;
          end else if (to_expired) begin
            rsp_d   = '{rdata: '0, resp: RESP_DECERR, timeout: 1'b1};
            state_d = ST_RSP;
          end
        end
        ST_RSP: begin
          rsp_valid = 1'b1;
          if (rsp_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_q     <= '0;
      stale_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rsp_q     <= rsp_d;
      if (cmd_take) begin
        addr_q <= cmd_in.addr;
        if (!cmd_in.rnw) begin
          wdata_q <= cmd_in.wdata;
          wstrb_q <= cmd_in.wstrb;
        end
      end
      if ((state_q == ST_IDLE) && (M_AXI_BVALID || M_AXI_RVALID)) stale_q <= 1'b1;
    end
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign rsp_rdata    = rsp_q.rdata;
  assign rsp_resp     = rsp_q.resp;
  assign rsp_timeout  = rsp_q.timeout;
  assign stale_rsp    = stale_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI4-Lite initiator: the master end of the register bus that our IP blocks (clock mux, IPIF-decoded cores) expose as slaves.
- Accepts single register read/write commands on a valid/ready command port and runs exactly one AXI4-Lite transaction per command.
- Returns data and response code on a valid/ready response port.
- Used by on-fabric sequencers and self-test logic to program and poll clock-control registers without a processor.

Parameters:
C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_M_AXI_ADDR_WIDTH, 11, AXI address width.
TIMEOUT_CYCLES, 1024, maximum cycles to wait for BVALID/RVALID; must be ≥2.

Ports:
clk  in  1  single clock for command, response and AXI sides.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when high with cmd_valid.
cmd_rnw  in  1  1=read, 0=write.
cmd_addr  in  ADDR_WIDTH  byte address.
cmd_wdata  in  DATA_WIDTH  write data.
cmd_wstrb  in  DATA_WIDTH/8  write strobes.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
rsp_resp  out  2  BRESP/RRESP; 2'b11 on timeout.
rsp_timeout  out  1  response produced by timeout.
stale_rsp  out  1  sticky; a B/R beat arrived while IDLE.
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths.

Behaviour:
- Reset: state IDLE. All M_AXI valid/ready outputs are 0; AWADDR/ARADDR/WDATA/WSTRB are 0. cmd_ready=0 during the reset cycle. rsp_valid, rsp_rdata, rsp_resp, rsp_timeout and stale_rsp are 0.
- Reset mid-transaction aborts immediately, even though this violates AXI. The slave must be reset in the same domain.
- AWPROT=ARPROT=3'b000 always.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready=1, BREADY=1, RREADY=1. BREADY/RREADY are held high to absorb stale beats.
  - A stale BVALID or RVALID beat sets stale_rsp. stale_rsp clears only on reset.
  - Command handshake with cmd_rnw=0: register addr/wdata/wstrb and go to WR_REQ.
  - Command handshake with cmd_rnw=1: register addr and go to RD_REQ.
  - A stale beat and a command handshake in the same cycle are both honoured.
- WR_REQ:
  - AWVALID and WVALID assert the cycle after command acceptance, both together.
  - Each drops independently on its own handshake; AW and W may complete in either order or the same cycle.
  - When both are done, go to WR_RESP.
  - No timeout in this state: AXI forbids withdrawing valid.
- WR_RESP:
  - BREADY=1 and the timeout counter runs.
  - On BVALID: capture BRESP, rdata=0, timeout=0, go to RSP.
  - If the counter reaches TIMEOUT_CYCLES first: resp=2'b11, timeout=1, BREADY drops, go to RSP.
- RD_REQ: ARVALID held until ARREADY, then go to RD_RESP.
- RD_RESP:
  - Same as WR_RESP, using RVALID/RDATA/RRESP.
  - Data is captured on the handshake cycle.
- RSP:
  - rsp_valid=1 with stable payload until rsp_ready.
  - Then go to IDLE; cmd_ready is high the following cycle.
  - cmd_ready=0, BREADY=0, RREADY=0.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to WR_RESP/RD_RESP; increments every cycle in those states; saturates.
  - The response handshake wins over timeout in the same cycle.
- Best-case latency (slave always ready, zero-wait response):
  - Write: cmd handshake at cycle 0, AW/W handshake at 1, B handshake at 2, rsp_valid at 3.
  - Read: rsp_valid at cycle 3.
- Throughput: one command per transaction; no outstanding transactions.

Decomposition:
- Shared package axil_master_pkg:
  - state enum.
  - AXI response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Packed cmd_t {rnw, addr, wdata, wstrb} and rsp_t {rdata, resp, timeout}.
- Sub-module axil_timeout_counter: clear/enable/expired outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write 0x00000001 to addr 0x000, WSTRB=4'hF, slave AWREADY=WREADY=1, BRESP=0 -> AW/W at cycle 1, rsp_valid at cycle 3, rsp_resp=0, rsp_timeout=0, rsp_rdata=0.
- Write where the slave raises WREADY 2 cycles before AWREADY, then the reverse order -> WVALID/AWVALID drop independently; exactly one write is logged at the slave; one response.
- Read addr 0x008, slave returns RDATA=0x00000001, RRESP=2'b00 after 3 wait cycles -> rsp_rdata=0x00000001, resp=0; ARVALID held for exactly one handshake.
- Read with slave never asserting RVALID, TIMEOUT_CYCLES=16 -> after 16 cycles in RD_RESP: rsp_resp=2'b11, rsp_timeout=1. A late RVALID injected in IDLE is absorbed and sets stale_rsp=1.
- rsp_ready held low for 10 cycles -> rsp_valid and payload stable; cmd_ready=0 throughout; cmd_ready=1 the cycle after the rsp handshake.
- reset asserted in WR_RESP -> next edge: all valids/readies 0, state IDLE, rsp_valid=0; a fresh write completes normally afterwards.
